ysyx_22040210_wb_stage: RTL and testbench

Writeback stage directly upstream of the GPR file; sole driver of its write port (we_i/waddr_i/wdata_i).
Accepts retiring instructions from MEM over a valid/ready handshake. Passes ALU results straight through. For loads, waits for the data-memory response, then aligns and sign/zero-extends the loaded value.

---
 rtl/ysyx_22040210_wb_stage_pkg.sv | 36 +++
 rtl/ysyx_22040210_wb_stage_if.sv | 35 +++
 rtl/ysyx_22040210_wb_stage_ld_ext.sv | 35 +++
 rtl/ysyx_22040210_wb_stage.sv | 194 +++++++++++++++++++
 tb/tb_ysyx_22040210_wb_stage.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22040210_wb_stage_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22040210_wb_stage_pkg
// Shared definitions for the writeback stage and the load extender:
//   - RegBUS / RegAddrBus / ZeroWord legacy macros used across the core
//   - load-size encodings (LD_B/LD_H/LD_W/LD_D)
//   - writeback FSM state encodings (IDLE/WAIT_LD)
//   - ld_fmt_t: the load-format fields captured while a load is pending
// ----------------------------------------------------------------------------
`ifndef YSYX_22040210_WB_STAGE_DEFS
`define YSYX_22040210_WB_STAGE_DEFS
`define RegBUS     63:0
`define RegAddrBus 4:0
`define ZeroWord   64'h0
`endif

package ysyx_22040210_wb_stage_pkg;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2,
    LD_D = 2'd3
  } ld_size_e;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_LD = 1'b1
  } wb_state_e;

  typedef struct packed {
    ld_size_e   size;
    logic       uns;
    logic [2:0] off;
  } ld_fmt_t;

endpackage

// File: rtl/ysyx_22040210_wb_stage_if.sv
// ----------------------------------------------------------------------------
// ysyx_22040210_wb_stage_if
// MEM -> WB retire handshake bundle.
//   master : MEM stage (drives valid and instruction fields, sees ready)
//   slave  : WB stage  (drives ready)
// Signals: mem_valid_i, mem_ready_o, mem_rd_i, mem_rd_we_i, mem_res_i,
//          mem_is_load_i, mem_ld_size_i, mem_ld_uns_i, mem_addr_off_i, mem_pc_i
// ----------------------------------------------------------------------------
interface ysyx_22040210_wb_stage_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 5
);
  logic              mem_valid_i;
  logic              mem_ready_o;
  logic [ADDR_W-1:0] mem_rd_i;
  logic              mem_rd_we_i;
  logic [XLEN-1:0]   mem_res_i;
  logic              mem_is_load_i;
  logic [1:0]        mem_ld_size_i;
  logic              mem_ld_uns_i;
  logic [2:0]        mem_addr_off_i;
  logic [XLEN-1:0]   mem_pc_i;

  modport master (
    output mem_valid_i, mem_rd_i, mem_rd_we_i, mem_res_i, mem_is_load_i,
           mem_ld_size_i, mem_ld_uns_i, mem_addr_off_i, mem_pc_i,
    input  mem_ready_o
  );

  modport slave (
    input  mem_valid_i, mem_rd_i, mem_rd_we_i, mem_res_i, mem_is_load_i,
           mem_ld_size_i, mem_ld_uns_i, mem_addr_off_i, mem_pc_i,
    output mem_ready_o
  );
endinterface

// File: rtl/ysyx_22040210_wb_stage_ld_ext.sv
// ----------------------------------------------------------------------------
// ysyx_22040210_ld_ext
// Combinational load aligner / extender, shared with the LSU.
//   raw  : raw doubleword returned by data memory
//   off  : byte offset of the load within the doubleword
//   size : LD_B / LD_H / LD_W / LD_D
//   uns  : 1 = zero-extend, 0 = sign-extend (ignored for LD_D)
//   ext  : aligned, extended result
// A misaligned access simply shifts in zeros from the top; no trap here.
// ----------------------------------------------------------------------------
module ysyx_22040210_ld_ext
  import ysyx_22040210_wb_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] raw,
  input  logic [2:0]      off,
  input  ld_size_e        size,
  input  logic            uns,
  output logic [XLEN-1:0] ext
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = raw >> {off, 3'b000};
    case (size)
      LD_B:    ext = {{(XLEN-8){~uns & shifted[7]}},   shifted[7:0]};
      LD_H:    ext = {{(XLEN-16){~uns & shifted[15]}}, shifted[15:0]};
      LD_W:    ext = {{(XLEN-32){~uns & shifted[31]}}, shifted[31:0]};
      default: ext = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_22040210_wb_stage.sv
// ----------------------------------------------------------------------------
// ysyx_22040210_wb_stage
// Writeback stage; sole driver of the GPR write port. ALU results retire one
// cycle after accept; loads park in WAIT_LD until the dmem response, then the
// data is aligned/extended and retired. All outputs are registered.
//
// Ports:
//   clk, rst            clock (rising edge), async active-low reset
//   mem                 MEM->WB handshake bundle (slave side)
//   dmem_rvalid_i/rdata load response (single-cycle pulse + raw doubleword)
//   rf_we_o/waddr/wdata regfile write port, one-cycle pulse per retire
//   commit_o            one-cycle retire pulse
//   ld_timeout_o        sticky: a load waited LD_TIMEOUT cycles with no data
//   commit_pc_o         PC of the retiring instruction
//                       (only with YSYX_22040210_WB_TRACE_EN defined)
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | ready for a new instruction; ALU ops retire next cycle
// WAIT_LD | load accepted, waiting for dmem_rvalid_i or timeout
// ----------------------------------------------------------------------------
module ysyx_22040210_wb_stage
  import ysyx_22040210_wb_stage_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int ADDR_W     = 5,
  parameter int LD_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_22040210_wb_stage_if.slave mem,
  input  logic                  dmem_rvalid_i,
  input  logic [XLEN-1:0]       dmem_rdata_i,
  output logic                  rf_we_o,
  output logic [ADDR_W-1:0]     rf_waddr_o,
  output logic [XLEN-1:0]       rf_wdata_o,
  output logic                  commit_o,
  output logic                  ld_timeout_o
`ifdef YSYX_22040210_WB_TRACE_EN
  ,
  output logic [XLEN-1:0]       commit_pc_o
`endif
);

  // 9-bit compare so the 8-bit counter can reach 255 without wrapping
  localparam logic [8:0] TIMEOUT_LIM = LD_TIMEOUT[8:0];

  wb_state_e         state, state_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic [8:0]        cnt_inc;
  logic              timeout_hit;

  logic [ADDR_W-1:0] ld_rd;
  logic              ld_rd_we;
  ld_fmt_t           ld_fmt;
  logic [XLEN-1:0]   ld_data;

  logic              ready;
  logic              accept;
  logic              retire;
  logic              we_nxt;
  logic [ADDR_W-1:0] waddr_nxt;
  logic [XLEN-1:0]   wdata_nxt;

  assign ready           = (state == IDLE);
  assign mem.mem_ready_o = ready;
  assign accept          = mem.mem_valid_i && ready;
  assign cnt_inc         = {1'b0, cnt} + 9'd1;

  ysyx_22040210_ld_ext #(.XLEN(XLEN)) u_ld_ext (
    .raw  (dmem_rdata_i),
    .off  (ld_fmt.off),
    .size (ld_fmt.size),
    .uns  (ld_fmt.uns),
    .ext  (ld_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; a response arriving on the last wait cycle still wins
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (accept && mem.mem_is_load_i) begin
          state_nxt = WAIT_LD;
          cnt_nxt   = '0;
        end
      end
      WAIT_LD: begin
        if (dmem_rvalid_i) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt_inc[7:0];
          if (cnt_inc >= TIMEOUT_LIM) begin
            state_nxt   = IDLE;
            timeout_hit = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic (values to be registered); address/data hold between retires
  always_comb begin
    retire    = 1'b0;
    we_nxt    = 1'b0;
    waddr_nxt = rf_waddr_o;
    wdata_nxt = rf_wdata_o;
    case (state)
      IDLE: begin
        if (accept && !mem.mem_is_load_i) begin
          retire    = 1'b1;
          we_nxt    = mem.mem_rd_we_i && (mem.mem_rd_i != '0);
          waddr_nxt = mem.mem_rd_i;
          wdata_nxt = mem.mem_res_i;
        end
      end
      WAIT_LD: begin
        if (dmem_rvalid_i) begin
          retire    = 1'b1;
          we_nxt    = ld_rd_we && (ld_rd != '0);
          waddr_nxt = ld_rd;
          wdata_nxt = ld_data;
        end
      end
      default: ;
    endcase
  end

  // Registered write port and status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we_o      <= 1'b0;
      rf_waddr_o   <= '0;
      rf_wdata_o   <= '0;
      commit_o     <= 1'b0;
      ld_timeout_o <= 1'b0;
    end else begin
      rf_we_o      <= we_nxt;
      rf_waddr_o   <= waddr_nxt;
      rf_wdata_o   <= wdata_nxt;
      commit_o     <= retire;
      ld_timeout_o <= ld_timeout_o | timeout_hit;
    end
  end

  // Pending-load context, captured only on a load accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_rd    <= '0;
      ld_rd_we <= 1'b0;
      ld_fmt   <= '0;
    end else if (accept && mem.mem_is_load_i) begin
      ld_rd       <= mem.mem_rd_i;
      ld_rd_we    <= mem.mem_rd_we_i;
      ld_fmt.size <= ld_size_e'(mem.mem_ld_size_i);
      ld_fmt.uns  <= mem.mem_ld_uns_i;
      ld_fmt.off  <= mem.mem_addr_off_i;
    end
  end

`ifdef YSYX_22040210_WB_TRACE_EN
  logic [XLEN-1:0] ld_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_pc       <= '0;
      commit_pc_o <= '0;
    end else begin
      if (accept && mem.mem_is_load_i)
        ld_pc <= mem.mem_pc_i;
      if (retire)
        commit_pc_o <= (state == WAIT_LD) ? ld_pc : mem.mem_pc_i;
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^mem.mem_pc_i;
`endif

endmodule

// File: tb/tb_ysyx_22040210_wb_stage.sv
`timescale 1ns/1ps
module tb_ysyx_22040210_wb_stage;
  import ysyx_22040210_wb_stage_pkg::*;

  localparam int XLEN       = 64;
  localparam int ADDR_W     = 5;
  localparam int LD_TIMEOUT = 255;
  localparam logic [63:0] RD_PAT = 64'h89AB_CDEF_F0E0_D0C0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dmem_rvalid_i = 1'b0;
  logic [63:0] dmem_rdata_i  = '0;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [63:0] rf_wdata_o;
  logic        commit_o;
  logic        ld_timeout_o;
`ifdef YSYX_22040210_WB_TRACE_EN
  logic [63:0] commit_pc_o;
`endif

  ysyx_22040210_wb_stage_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) mif ();

  ysyx_22040210_wb_stage #(.XLEN(XLEN), .ADDR_W(ADDR_W), .LD_TIMEOUT(LD_TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem           (mif),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .rf_we_o       (rf_we_o),
    .rf_waddr_o    (rf_waddr_o),
    .rf_wdata_o    (rf_wdata_o),
    .commit_o      (commit_o),
    .ld_timeout_o  (ld_timeout_o)
`ifdef YSYX_22040210_WB_TRACE_EN
    ,
    .commit_pc_o   (commit_pc_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_load;
    logic [4:0]  rd;
    logic        rd_we;
    logic [63:0] res;
    logic [1:0]  size;
    logic        uns;
    logic [2:0]  off;
    logic [63:0] rdata;
    int          delay;
    logic [63:0] pc;
    logic        exp_we;
    logic [63:0] exp_wdata;
  } vec_t;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: shift right by whole bytes, keep 8<<size bits, sign-fill if signed
  function automatic logic [63:0] ext_ref(input logic [63:0] raw, input int off,
                                          input int size, input bit uns);
    logic [63:0] s;
    logic [63:0] m;
    int nbits;
    s = raw >> (8 * off);
    if (size == 3) return s;
    nbits = 8 << size;
    m = (64'd1 << nbits) - 64'd1;
    s = s & m;
    if (!uns && s[nbits-1]) s = s | ~m;
    return s;
  endfunction

  function automatic vec_t mkv(input logic is_load, input logic [4:0] rd, input logic rd_we,
                               input logic [63:0] res, input logic [1:0] size, input logic uns,
                               input logic [2:0] off, input logic [63:0] rdata, input int delay,
                               input logic exp_we, input logic [63:0] exp_wdata);
    vec_t v;
    v.is_load = is_load; v.rd = rd; v.rd_we = rd_we; v.res = res;
    v.size = size; v.uns = uns; v.off = off; v.rdata = rdata; v.delay = delay;
    v.pc = 64'h8000_0000 + {54'd0, rd, 5'd0};
    v.exp_we = exp_we; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  task automatic run_instr(input vec_t v, input string tag);
    chk({tag, " ready_before"}, mif.mem_ready_o, 1'b1);
    mif.mem_valid_i    = 1'b1;
    mif.mem_is_load_i  = v.is_load;
    mif.mem_rd_i       = v.rd;
    mif.mem_rd_we_i    = v.rd_we;
    mif.mem_res_i      = v.res;
    mif.mem_ld_size_i  = v.size;
    mif.mem_ld_uns_i   = v.uns;
    mif.mem_addr_off_i = v.off;
    mif.mem_pc_i       = v.pc;
    step();
    mif.mem_valid_i = 1'b0;
    if (v.is_load) begin
      chk({tag, " ready_wait"}, mif.mem_ready_o, 1'b0);
      chk({tag, " commit_wait"}, commit_o, 1'b0);
      for (int i = 0; i < v.delay; i++) begin
        step();
        chk({tag, " ready_wait"}, mif.mem_ready_o, 1'b0);
        chk({tag, " we_wait"}, rf_we_o, 1'b0);
      end
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = v.rdata;
      step();
      dmem_rvalid_i = 1'b0;
    end
    chk({tag, " commit"}, commit_o, 1'b1);
    chk({tag, " we"}, rf_we_o, v.exp_we);
    chk({tag, " wdata"}, rf_wdata_o, v.exp_wdata);
    if (v.exp_we) chk({tag, " waddr"}, rf_waddr_o, v.rd);
    chk({tag, " ready_after"}, mif.mem_ready_o, 1'b1);
`ifdef YSYX_22040210_WB_TRACE_EN
    chk({tag, " commit_pc"}, commit_pc_o, v.pc);
`endif
  endtask

  vec_t tbl[14];

  initial begin
    int k;
    bit seen_retire;
    vec_t rv;

    tbl[0]  = mkv(1, 5'd4,  1, 64'h0, LD_B, 0, 3'd3, 64'h0000_0000_80FF_0000, 4, 1, 64'hFFFF_FFFF_FFFF_FF80);
    tbl[1]  = mkv(1, 5'd5,  1, 64'h0, LD_B, 1, 3'd3, 64'h0000_0000_80FF_0000, 0, 1, 64'h0000_0000_0000_0080);
    tbl[2]  = mkv(1, 5'd6,  1, 64'h0, LD_H, 1, 3'd4, RD_PAT, 1, 1, 64'h0000_0000_0000_CDEF);
    tbl[3]  = mkv(1, 5'd7,  1, 64'h0, LD_W, 0, 3'd4, RD_PAT, 2, 1, 64'hFFFF_FFFF_89AB_CDEF);
    tbl[4]  = mkv(1, 5'd8,  1, 64'h0, LD_D, 0, 3'd0, RD_PAT, 0, 1, RD_PAT);
    tbl[5]  = mkv(1, 5'd9,  1, 64'h0, LD_H, 0, 3'd7, RD_PAT, 3, 1, 64'h0000_0000_0000_0089);
    tbl[6]  = mkv(1, 5'd10, 1, 64'h0, LD_W, 1, 3'd4, RD_PAT, 1, 1, 64'h0000_0000_89AB_CDEF);
    tbl[7]  = mkv(1, 5'd11, 1, 64'h0, LD_D, 1, 3'd4, RD_PAT, 0, 1, 64'h0000_0000_89AB_CDEF);
    tbl[8]  = mkv(0, 5'd0,  1, 64'hDEAD, LD_B, 0, 3'd0, 64'h0, 0, 0, 64'hDEAD);
    tbl[9]  = mkv(0, 5'd12, 0, 64'hBEEF, LD_B, 0, 3'd0, 64'h0, 0, 0, 64'hBEEF);
    tbl[10] = mkv(1, 5'd0,  1, 64'h0, LD_B, 0, 3'd0, 64'h7F, 2, 0, 64'h7F);
    tbl[11] = mkv(1, 5'd14, 1, 64'h0, LD_H, 0, 3'd2, RD_PAT, 0, 1, 64'hFFFF_FFFF_FFFF_F0E0);
    tbl[12] = mkv(1, 5'd13, 1, 64'h0, LD_B, 0, 3'd0, RD_PAT, 1, 1, 64'hFFFF_FFFF_FFFF_FFC0);
    tbl[13] = mkv(1, 5'd15, 1, 64'h0, LD_W, 0, 3'd0, RD_PAT, 5, 1, 64'hFFFF_FFFF_F0E0_D0C0);

    mif.mem_valid_i = 1'b0; mif.mem_is_load_i = 1'b0; mif.mem_rd_i = '0;
    mif.mem_rd_we_i = 1'b0; mif.mem_res_i = '0; mif.mem_ld_size_i = '0;
    mif.mem_ld_uns_i = 1'b0; mif.mem_addr_off_i = '0; mif.mem_pc_i = '0;

    // Reset values
    #2;
    chk("rst we", rf_we_o, 1'b0);
    chk("rst waddr", rf_waddr_o, 5'd0);
    chk("rst wdata", rf_wdata_o, 64'd0);
    chk("rst commit", commit_o, 1'b0);
    chk("rst timeout", ld_timeout_o, 1'b0);
    chk("rst ready", mif.mem_ready_o, 1'b1);
`ifdef YSYX_22040210_WB_TRACE_EN
    chk("rst commit_pc", commit_pc_o, 64'd0);
`endif
    #10 rst = 1'b1;
    step();

    // Back-to-back ALU stream
    for (int i = 0; i < 3; i++) begin
      mif.mem_valid_i   = 1'b1;
      mif.mem_is_load_i = 1'b0;
      mif.mem_rd_i      = 5'(i + 1);
      mif.mem_rd_we_i   = 1'b1;
      mif.mem_res_i     = 64'(17 * (i + 1));
      step();
      chk("alu_stream ready", mif.mem_ready_o, 1'b1);
      chk("alu_stream we", rf_we_o, 1'b1);
      chk("alu_stream waddr", rf_waddr_o, 64'(i + 1));
      chk("alu_stream wdata", rf_wdata_o, 64'(17 * (i + 1)));
      chk("alu_stream commit", commit_o, 1'b1);
    end
    mif.mem_valid_i = 1'b0;
    step();
    chk("alu_stream we_drop", rf_we_o, 1'b0);
    chk("alu_stream commit_drop", commit_o, 1'b0);

    // Directed vector table
    for (int i = 0; i < 14; i++) run_instr(tbl[i], $sformatf("vec%0d", i));

    // Randomized stream against the reference model
    for (int i = 0; i < 150; i++) begin
      rv.is_load = 1'($urandom_range(0, 1));
      rv.rd      = 5'($urandom);
      rv.rd_we   = 1'($urandom_range(0, 3) != 0);
      rv.res     = {$urandom, $urandom};
      rv.size    = 2'($urandom);
      rv.uns     = 1'($urandom);
      rv.off     = 3'($urandom);
      rv.rdata   = {$urandom, $urandom};
      rv.delay   = $urandom_range(0, 6);
      rv.pc      = {32'd0, $urandom};
      rv.exp_we  = rv.rd_we && (rv.rd != 5'd0);
      rv.exp_wdata = rv.is_load ? ext_ref(rv.rdata, int'(rv.off), int'(rv.size), rv.uns) : rv.res;
      run_instr(rv, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 2) == 0) begin
        dmem_rvalid_i = 1'($urandom);
        dmem_rdata_i  = {$urandom, $urandom};
        step();
        dmem_rvalid_i = 1'b0;
        chk("idle commit", commit_o, 1'b0);
        chk("idle we", rf_we_o, 1'b0);
      end
    end

    // Load timeout
    chk("to ready_before", mif.mem_ready_o, 1'b1);
    mif.mem_valid_i = 1'b1; mif.mem_is_load_i = 1'b1; mif.mem_rd_i = 5'd7;
    mif.mem_rd_we_i = 1'b1; mif.mem_ld_size_i = LD_D;
    step();
    mif.mem_valid_i = 1'b0;
    k = 0;
    seen_retire = 1'b0;
    while (ld_timeout_o !== 1'b1 && k < 300) begin
      if (commit_o || rf_we_o) seen_retire = 1'b1;
      step();
      k++;
    end
    chk("to cycles", 64'(k), 64'(LD_TIMEOUT));
    chk("to flag", ld_timeout_o, 1'b1);
    chk("to ready", mif.mem_ready_o, 1'b1);
    chk("to commit", commit_o, 1'b0);
    chk("to we", rf_we_o, 1'b0);
    chk("to no_retire_during_wait", seen_retire, 1'b0);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'h1234;
    step();
    dmem_rvalid_i = 1'b0;
    chk("to stray commit", commit_o, 1'b0);
    chk("to stray we", rf_we_o, 1'b0);
    chk("to sticky", ld_timeout_o, 1'b1);
    run_instr(mkv(0, 5'd9, 1, 64'h5A5A, LD_B, 0, 3'd0, 64'h0, 0, 1, 64'h5A5A), "after_to");
    chk("to sticky2", ld_timeout_o, 1'b1);

    // Async reset while a load is pending
    mif.mem_valid_i = 1'b1; mif.mem_is_load_i = 1'b1; mif.mem_rd_i = 5'd10;
    mif.mem_rd_we_i = 1'b1; mif.mem_ld_size_i = LD_D;
    step();
    mif.mem_valid_i = 1'b0;
    step();
    chk("arst ready_pre", mif.mem_ready_o, 1'b0);
    #3 rst = 1'b0;
    #1;
    chk("arst we", rf_we_o, 1'b0);
    chk("arst waddr", rf_waddr_o, 5'd0);
    chk("arst wdata", rf_wdata_o, 64'd0);
    chk("arst commit", commit_o, 1'b0);
    chk("arst timeout", ld_timeout_o, 1'b0);
    chk("arst ready", mif.mem_ready_o, 1'b1);
    #2 rst = 1'b1;
    step();
    chk("arst ready_post", mif.mem_ready_o, 1'b1);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'hFFFF;
    step();
    dmem_rvalid_i = 1'b0;
    chk("arst late_rvalid commit", commit_o, 1'b0);
    chk("arst late_rvalid we", rf_we_o, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
